// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler
//   Round-robin scheduler sharing one downstream resource among 4 requesters.
//   Issues a registered one-hot grant, bounds each ownership with a hold counter,
//   and inserts a one-cycle dead gap (RELEASE) between owners.
// Ports
//   clk      in   1  system clock, rising edge
//   reset_p  in   1  asynchronous active-high reset
//   req      in   4  level request per requester
//   done     in   1  current owner finished (sampled only in GRANT)
//   grant    out  4  registered one-hot grant, zero when nobody owns
//   owner    out  2  index of current/last granted requester
//   busy     out  1  high while in GRANT
//   timeout  out  1  one-cycle pulse when an ownership is ended by MAX_HOLD
module rr_grant_scheduler #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrant   = 2'd1,
        StRelease = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // Round-robin search starting just after the last served requester.
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        win   = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = last_q + 2'(i + 1);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    logic at_max;
    logic release_now;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
        at_max      = (cnt_q == CntMax);
        release_now = done || !req[owner_q] || at_max;

        case (state_q)
            StIdle, StRelease: begin
                if (found) begin
                    state_d = StGrant;
                    grant_d = 4'(4'b0001 << win);
                    owner_d = win;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                    grant_d = 4'b0000;
                end
            end
            StGrant: begin
                if (release_now) begin
                    state_d   = StRelease;
                    grant_d   = 4'b0000;
                    last_d    = owner_q;
                    // Only a pure limit expiry counts as a timeout.
                    timeout_d = at_max && !done && req[owner_q];
                end else begin
                    cnt_d = at_max ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q   <= StIdle;
            grant_q   <= 4'b0000;
            owner_q   <= 2'd0;
            last_q    <= 2'd3;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign busy    = (state_q == StGrant);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler: table-driven vectors plus hand sequences
// for hold-limit timeout, done at the limit, and asynchronous reset mid-grant.
module tb_rr_grant_scheduler;

    logic       clk = 1'b0;
    logic       reset_p = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int failures = 0;

    rr_grant_scheduler #(
        .MAX_HOLD(16),
        .CNT_W   (4)
    ) dut (
        .clk    (clk),
        .reset_p(reset_p),
        .req    (req),
        .done   (done),
        .grant  (grant),
        .owner  (owner),
        .busy   (busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] g;
        logic [1:0] o;
        logic       b;
        logic       t;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input logic [3:0] r, input logic d, input logic [3:0] g,
                       input logic [1:0] o, input logic b, input logic t);
        vec_t v;
        v.rst = rst; v.req = r; v.done = d; v.g = g; v.o = o; v.b = b; v.t = t;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge, so the pulse stays clear of the next edge.
    task automatic pulse_reset();
        reset_p = 1'b1;
        #3;
        reset_p = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] o,
                             input logic b, input logic t);
        check({tag, ".grant"}, {4'b0, grant}, {4'b0, g});
        check({tag, ".owner"}, {6'b0, owner}, {6'b0, o});
        check({tag, ".busy"}, {7'b0, busy}, {7'b0, b});
        check({tag, ".timeout"}, {7'b0, timeout}, {7'b0, t});
    endtask

    // Steps until grant clears; returns number of steps taken while still granted.
    task automatic run_until_release(output int n);
        n = 0;
        while (grant != 4'b0000 && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) check("release_bound", 8'd1, 8'd0);
    endtask

    initial begin
        int n;

        // Test 1: single requester, done pulse, regrant after the gap.
        add(1, 4'b0001, 0, 4'b0001, 0, 1, 0);
        add(0, 4'b0001, 0, 4'b0001, 0, 1, 0);
        add(0, 4'b0001, 0, 4'b0001, 0, 1, 0);
        add(0, 4'b0001, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0001, 0, 4'b0001, 0, 1, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        // Test 2: all requesting, rotation 0,1,2,3,0 with gaps.
        add(1, 4'b1111, 0, 4'b0001, 0, 1, 0);
        add(0, 4'b1111, 0, 4'b0001, 0, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 0, 4'b0010, 1, 1, 0);
        add(0, 4'b1111, 0, 4'b0010, 1, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 1, 0, 0);
        add(0, 4'b1111, 0, 4'b0100, 2, 1, 0);
        add(0, 4'b1111, 0, 4'b0100, 2, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 2, 0, 0);
        add(0, 4'b1111, 0, 4'b1000, 3, 1, 0);
        add(0, 4'b1111, 0, 4'b1000, 3, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 3, 0, 0);
        add(0, 4'b1111, 0, 4'b0001, 0, 1, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        // Test 4: owner 1 drops its request; next grant goes to 2.
        add(0, 4'b0110, 0, 4'b0010, 1, 1, 0);
        add(0, 4'b0110, 0, 4'b0010, 1, 1, 0);
        add(0, 4'b0100, 0, 4'b0000, 1, 0, 0);
        add(0, 4'b0100, 0, 4'b0100, 2, 1, 0);
        add(0, 4'b0000, 0, 4'b0000, 2, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 2, 0, 0);

        // Reset state.
        step();
        pulse_reset();
        check_all("reset", 4'b0000, 0, 0, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) pulse_reset();
            req  = vecs[i].req;
            done = vecs[i].done;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].g, vecs[i].o, vecs[i].b, vecs[i].t);
        end
        done = 1'b0;

        // Test 3: hold limit of 16 cycles, timeout pulse, regrant after gap.
        pulse_reset();
        req = 4'b0100;
        step();
        check("t3.first_grant", {4'b0, grant}, 8'h04);
        run_until_release(n);
        check("t3.hold_cycles", 8'(n), 8'd16);
        check_all("t3.released", 4'b0000, 2, 0, 1);
        step();
        check_all("t3.regrant", 4'b0100, 2, 1, 0);
        // Others requesting now: after the timeout, requester 0 is next, not 2.
        req = 4'b0111;
        run_until_release(n);
        check("t3.hold_cycles2", 8'(n), 8'd16);
        check("t3.timeout2", {7'b0, timeout}, 8'd1);
        step();
        check_all("t3.rotate", 4'b0001, 0, 1, 0);

        // Test 5: done coincident with count at the limit -> no timeout.
        pulse_reset();
        req = 4'b1000;
        step();
        for (int i = 0; i < 15; i++) step();
        check("t5.still_granted", {4'b0, grant}, 8'h08);
        done = 1'b1;
        step();
        done = 1'b0;
        check_all("t5.release", 4'b0000, 3, 0, 0);

        // Test 6: async reset mid-grant restores the pointer to 3.
        pulse_reset();
        req = 4'b1111;
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        step();
        check_all("t6.owner1", 4'b0010, 1, 1, 0);
        #2;
        reset_p = 1'b1;
        #1;
        check_all("t6.async", 4'b0000, 0, 0, 0);
        #2;
        reset_p = 1'b0;
        step();
        check_all("t6.first", 4'b0001, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
